// File: rtl/fft16_feeder.sv
// Ping-pong input buffer that gathers 16-sample complex frames and streams
// them into an FFT16 core with START/ED framing, plus optional zero frames.
module fft16_feeder #(
  parameter int NB = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [NB-1:0] IN_DR,
  input  logic [NB-1:0] IN_DI,
  input  logic          FLUSH,
  output logic          START,
  output logic          ED,
  output logic [NB-1:0] DOR,
  output logic [NB-1:0] DOI,
  output logic [7:0]    FRAMES
);

  typedef enum logic [1:0] {IDLE, SYNC, STREAM, ZERO} state_t;

  state_t            state, state_nx;
  logic [2*NB-1:0]   mem [2][16];
  logic [1:0]        full, full_nx;
  logic              wb, rb;
  logic [3:0]        wi, ri;
  logic              wr_en, wr_done, rd_last;

  assign IN_READY = ~full[wb];
  assign wr_en    = IN_VALID & IN_READY;
  assign wr_done  = wr_en & (wi == 4'd15);
  assign rd_last  = (state == STREAM) & (ri == 4'd15);

  // Write completion and read completion always target different banks.
  always_comb begin
    full_nx = full;
    if (wr_done) full_nx[wb] = 1'b1;
    if (rd_last) full_nx[rb] = 1'b0;
  end

  // Back-to-back decision looks at the flag including a same-cycle write
  // completion so a matched-rate writer never forces a gap.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (full[rb])
          state_nx = SYNC;
        else if (FLUSH && (wi == 4'd0))
          state_nx = ZERO;
      end
      SYNC:   state_nx = STREAM;
      STREAM: begin
        if (ri == 4'd15)
          state_nx = full_nx[~rb] ? STREAM : IDLE;
      end
      ZERO: begin
        if (ri == 4'd15)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (wr_en && !RST)
      mem[wb][wi] <= {IN_DR, IN_DI};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      full   <= '0;
      wb     <= 1'b0;
      rb     <= 1'b0;
      wi     <= '0;
      ri     <= '0;
      START  <= 1'b0;
      ED     <= 1'b0;
      DOR    <= '0;
      DOI    <= '0;
      FRAMES <= '0;
    end else begin
      state <= state_nx;
      full  <= full_nx;
      START <= (state == SYNC);
      ED    <= (state == STREAM) || (state == ZERO);
      if (wr_en) begin
        wi <= wi + 4'd1;
        if (wr_done) wb <= ~wb;
      end
      case (state)
        STREAM: begin
          {DOR, DOI} <= mem[rb][ri];
          ri         <= ri + 4'd1;
          if (ri == 4'd15) begin
            rb     <= ~rb;
            FRAMES <= FRAMES + 8'd1;
          end
        end
        ZERO: begin
          DOR <= '0;
          DOI <= '0;
          ri  <= ri + 4'd1;
          if (ri == 4'd15) FRAMES <= FRAMES + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_feeder.sv
// Directed self-checking bench for fft16_feeder: reset, single frame,
// back-to-back frames, gapped input, flush frames and mid-frame reset.
module tb_fft16_feeder;
  localparam int NB = 12;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [NB-1:0] IN_DR = '0;
  logic [NB-1:0] IN_DI = '0;
  logic          FLUSH = 1'b0;
  logic          START, ED;
  logic [NB-1:0] DOR, DOI;
  logic [7:0]    FRAMES;

  int errors = 0;
  int checks = 0;

  fft16_feeder #(.NB(NB)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DR(IN_DR), .IN_DI(IN_DI), .FLUSH(FLUSH), .START(START), .ED(ED),
    .DOR(DOR), .DOI(DOI), .FRAMES(FRAMES)
  );

  always #5 CLK = ~CLK;

  // Output monitor: records every strobed sample and START pulse with its cycle.
  int              cyc = 0;
  int              nready_cnt = 0;
  logic [2*NB-1:0] out_q[$];
  int              ed_cyc[$];
  int              start_cyc[$];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (ED) begin
      out_q.push_back({DOR, DOI});
      ed_cyc.push_back(cyc);
    end
    if (START) start_cyc.push_back(cyc);
    if (!RST && !IN_READY) nready_cnt = nready_cnt + 1;
  end

  function automatic logic [2*NB-1:0] exp_word(input int v);
    logic [31:0] p;
    logic [31:0] n;
    p = v;
    n = -v;
    return {p[NB-1:0], n[NB-1:0]};
  endfunction

  // Called just after a rising edge; leaves inputs idle just after a rising edge.
  task automatic write_samples(input int n, input int base, input bit gapped);
    int k = 0;
    int c = 0;
    bit acc;
    while (k < n && c < 2000) begin
      IN_VALID = gapped ? (c % 2 == 0) : 1'b1;
      IN_DR    = exp_word(base + k) >> NB;
      IN_DI    = exp_word(base + k);
      @(negedge CLK);
      acc = IN_VALID && IN_READY;
      @(posedge CLK); #1;
      if (acc) k++;
      c++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (k != n) begin
      errors++;
      $display("FAIL write_count: accepted %0d required %0d", k, n);
    end
  endtask

  task automatic wait_out(input int target);
    int g = 0;
    while (out_q.size() < target && g < 300) begin
      @(negedge CLK);
      g++;
    end
    @(posedge CLK); #1;
    checks++;
    if (out_q.size() < target) begin
      errors++;
      $display("FAIL wait_out: got %0d samples required %0d", out_q.size(), target);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check_data(input string name, input int s0, input int n, input int base, input bit zeros);
    for (int i = 0; i < n; i++) begin
      logic [2*NB-1:0] e;
      e = zeros ? '0 : exp_word(base + i);
      checks++;
      if (out_q[s0 + i] !== e) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h required %h", name, i, out_q[s0 + i], e);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; IN_VALID = 1'b1; FLUSH = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({START, ED, DOR, DOI, FRAMES} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {START, ED, DOR, DOI, FRAMES});
    end
    @(posedge CLK); #1;
    RST = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b0;
    @(negedge CLK);
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", IN_READY);
    end
    idle(20);
    check_int("reset_no_ed", out_q.size(), 0);
  endtask

  task automatic test_single_frame;
    int s0 = out_q.size();
    int t0 = start_cyc.size();
    write_samples(16, 0, 1'b0);
    wait_out(s0 + 16);
    idle(4);
    check_int("single_starts", start_cyc.size() - t0, 1);
    check_int("single_start_pos", start_cyc[t0], ed_cyc[s0] - 1);
    check_int("single_contig", ed_cyc[s0 + 15] - ed_cyc[s0], 15);
    check_data("single", s0, 16, 0, 1'b0);
    check_int("single_frames", FRAMES, 1);
  endtask

  task automatic test_back_to_back;
    int s0 = out_q.size();
    int t0 = start_cyc.size();
    int n0 = nready_cnt;
    write_samples(48, 100, 1'b0);
    wait_out(s0 + 48);
    idle(4);
    check_int("b2b_starts", start_cyc.size() - t0, 1);
    check_int("b2b_contig", ed_cyc[s0 + 47] - ed_cyc[s0], 47);
    check_int("b2b_backpressure", (nready_cnt > n0) ? 1 : 0, 1);
    check_data("b2b", s0, 48, 100, 1'b0);
    check_int("b2b_frames", FRAMES, 4);
  endtask

  task automatic test_gapped;
    int s0 = out_q.size();
    int t0 = start_cyc.size();
    write_samples(32, 200, 1'b1);
    wait_out(s0 + 32);
    idle(4);
    check_int("gap_starts", start_cyc.size() - t0, 2);
    check_int("gap_start0_pos", start_cyc[t0], ed_cyc[s0] - 1);
    check_int("gap_start1_pos", start_cyc[t0 + 1], ed_cyc[s0 + 16] - 1);
    check_data("gap", s0, 32, 200, 1'b0);
    check_int("gap_frames", FRAMES, 6);
  endtask

  task automatic test_flush;
    int s0 = out_q.size();
    int t0 = start_cyc.size();
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    wait_out(s0 + 16);
    idle(4);
    check_int("flush_starts", start_cyc.size() - t0, 0);
    check_int("flush_contig", ed_cyc[s0 + 15] - ed_cyc[s0], 15);
    check_int("flush_len", out_q.size() - s0, 16);
    check_data("flush", s0, 16, 0, 1'b1);
    check_int("flush_frames", FRAMES, 7);
    // Partial frame pending: a flush request must be ignored.
    s0 = out_q.size();
    write_samples(5, 300, 1'b0);
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    idle(40);
    check_int("flush_partial_no_ed", out_q.size() - s0, 0);
    check_int("flush_partial_frames", FRAMES, 7);
    t0 = start_cyc.size();
    write_samples(11, 305, 1'b0);
    wait_out(s0 + 16);
    idle(4);
    check_int("flush_resume_starts", start_cyc.size() - t0, 1);
    check_data("flush_resume", s0, 16, 300, 1'b0);
    check_int("flush_resume_frames", FRAMES, 8);
  endtask

  task automatic test_reset_midframe;
    int s0 = out_q.size();
    int s1, t0;
    write_samples(32, 400, 1'b0);
    // Second bank is now full and the first frame is still streaming.
    check_int("mid_in_frame", (out_q.size() - s0 > 0 && out_q.size() - s0 < 16) ? 1 : 0, 1);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({ED, START, FRAMES, IN_READY} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset_state: got ED=%b START=%b FRAMES=%0d IN_READY=%b required 0 0 0 1",
               ED, START, FRAMES, IN_READY);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    s1 = out_q.size();
    idle(30);
    check_int("mid_no_ed", out_q.size() - s1, 0);
    t0 = start_cyc.size();
    write_samples(16, 500, 1'b0);
    wait_out(s1 + 16);
    idle(4);
    check_int("mid_starts", start_cyc.size() - t0, 1);
    check_int("mid_start_pos", start_cyc[t0], ed_cyc[s1] - 1);
    check_data("mid", s1, 16, 500, 1'b0);
    check_int("mid_frames", FRAMES, 1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_flush();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
